// File: rtl/sel_acc_reg_if.sv
// Operand/result bundle for the selectable accumulator register.
// There is no valid/ready pair on this bus: the controller raises
// enable for exactly the cycles it wants an operation, and every
// enable-high cycle is an accepted operation whose result is visible
// on q/carry/ovf/ops after the next rising clock edge.
interface sel_acc_reg_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 4
);
  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic                    enable;
  logic [SEL_W-1:0]        sel;
  logic [1:0]              mode;
  logic [NUM_IN*WIDTH-1:0] d;
  logic [WIDTH-1:0]        q;
  logic                    carry;
  logic                    zero;
  logic                    ovf;
  logic [CNT_W-1:0]        ops;

  // Operand side: drives the operation, observes the result.
  modport master (
    output enable, sel, mode, d,
    input  q, carry, zero, ovf, ops
  );

  // Register side: consumes the operation, produces the result.
  modport slave (
    input  enable, sel, mode, d,
    output q, carry, zero, ovf, ops
  );
endinterface

// File: rtl/sel_acc_reg.sv
// N-channel selectable accumulator register. Each enabled cycle picks
// one input channel and loads it, adds it, subtracts it, or rotates the
// stored word left. Tracks carry/borrow, a sticky overflow flag and a
// saturating count of enabled operations. zero is a pure decode of q.
module sel_acc_reg #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 4
) (
  input  logic          clk,
  input  logic          reset,
  sel_acc_reg_if.slave  bus
);
  localparam logic [1:0] MODE_LOAD = 2'b00;
  localparam logic [1:0] MODE_ADD  = 2'b01;
  localparam logic [1:0] MODE_SUB  = 2'b10;
  localparam logic [1:0] MODE_ROTL = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] ops_q, ops_d;

  logic [WIDTH-1:0] x;
  logic [WIDTH:0]   sum;
  logic             borrow;

  // Operand select; an out-of-range select falls back to channel 0.
  always_comb begin
    x = bus.d[WIDTH-1:0];
    for (int k = 1; k < NUM_IN; k++) begin
      if (int'(bus.sel) == k) x = bus.d[k*WIDTH +: WIDTH];
    end
  end

  // Arithmetic helpers shared by the next-state logic.
  always_comb begin
    sum    = {1'b0, q_q} + {1'b0, x};
    borrow = (x > q_q);
  end

  // Next-state: hold unless enabled, then apply the selected mode.
  always_comb begin
    q_d     = q_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    ops_d   = ops_q;
    if (bus.enable) begin
      if (ops_q != {CNT_W{1'b1}}) ops_d = ops_q + CNT_W'(1);
      unique case (bus.mode)
        MODE_LOAD: begin
          q_d     = x;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
        end
        MODE_ADD: begin
          q_d     = sum[WIDTH-1:0];
          carry_d = sum[WIDTH];
          ovf_d   = ovf_q | sum[WIDTH];
        end
        MODE_SUB: begin
          q_d     = q_q - x;
          carry_d = borrow;
          ovf_d   = ovf_q | borrow;
        end
        MODE_ROTL: begin
          q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          carry_d = q_q[WIDTH-1];
        end
        default: ;
      endcase
    end
  end

  // State register; active-low reset wins over everything else.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      ops_q   <= '0;
    end else begin
      q_q     <= q_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      ops_q   <= ops_d;
    end
  end

  assign bus.q     = q_q;
  assign bus.carry = carry_q;
  assign bus.ovf   = ovf_q;
  assign bus.ops   = ops_q;
  assign bus.zero  = (q_q == '0);
endmodule

// File: tb/tb_sel_acc_reg.sv
// Bench for sel_acc_reg: directed walk through load/add/sub/rotate,
// counter saturation and mid-operation reset, a randomized run against
// an integer reference model, and a three-channel build exercising the
// out-of-range select.
module tb_sel_acc_reg;
  localparam logic [1:0] LOAD = 2'b00;
  localparam logic [1:0] ADD  = 2'b01;
  localparam logic [1:0] SUB  = 2'b10;
  localparam logic [1:0] ROTL = 2'b11;

  logic clk;
  logic reset;

  int n_pass;
  int n_total;

  // Reference model state, plain integers.
  int m_q, m_c, m_ovf, m_ops;

  sel_acc_reg_if #(.WIDTH(8), .NUM_IN(2), .CNT_W(4)) bus2 ();
  sel_acc_reg_if #(.WIDTH(8), .NUM_IN(3), .CNT_W(4)) bus3 ();

  sel_acc_reg #(.WIDTH(8), .NUM_IN(2), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  sel_acc_reg #(.WIDTH(8), .NUM_IN(3), .CNT_W(4)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag, input int q, input int c, input int o, input int n);
    check({tag, ".q"},     32'(bus2.q),     32'(q));
    check({tag, ".carry"}, 32'(bus2.carry), 32'(c));
    check({tag, ".ovf"},   32'(bus2.ovf),   32'(o));
    check({tag, ".ops"},   32'(bus2.ops),   32'(n));
    check({tag, ".zero"},  32'(bus2.zero),  32'(q == 0));
  endtask

  // Driver: apply one cycle's inputs to the 2-channel DUT, wait for the
  // edge, then settle before sampling.
  task automatic step(input logic rst_n, input logic en, input logic [1:0] md,
                      input logic s, input logic [7:0] a, input logic [7:0] b);
    reset       = rst_n;
    bus2.enable = en;
    bus2.mode   = md;
    bus2.sel    = s;
    bus2.d      = {b, a};
    @(posedge clk);
    #1;
  endtask

  task automatic step3(input logic [1:0] md, input logic [1:0] s, input logic [23:0] dd);
    reset       = 1'b1;
    bus2.enable = 1'b0;
    bus3.enable = 1'b1;
    bus3.mode   = md;
    bus3.sel    = s;
    bus3.d      = dd;
    @(posedge clk);
    #1;
    bus3.enable = 1'b0;
  endtask

  // Reference model: one cycle of the accumulator in plain arithmetic.
  task automatic model(input bit rst_n, input bit en, input int md, input int x);
    if (!rst_n) begin
      m_q = 0; m_c = 0; m_ovf = 0; m_ops = 0;
    end else if (en) begin
      m_ops = (m_ops + 1 > 15) ? 15 : m_ops + 1;
      case (md)
        0: begin m_q = x; m_c = 0; m_ovf = 0; end
        1: begin
          m_c   = (m_q + x > 255) ? 1 : 0;
          m_q   = (m_q + x) % 256;
          m_ovf = m_ovf | m_c;
        end
        2: begin
          m_c   = (x > m_q) ? 1 : 0;
          m_q   = (m_q - x + 256) % 256;
          m_ovf = m_ovf | m_c;
        end
        default: begin
          m_c = m_q / 128;
          m_q = (m_q * 2) % 256 + m_c;
        end
      endcase
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b0;
    bus2.enable = 1'b0; bus2.mode = LOAD; bus2.sel = 1'b0; bus2.d = '0;
    bus3.enable = 1'b0; bus3.mode = LOAD; bus3.sel = 2'd0; bus3.d = '0;
    @(negedge clk);

    // Reset with an enabled LOAD pending: reset wins.
    step(1'b0, 1'b1, LOAD, 1'b0, 8'h55, 8'h00);
    check_all("reset", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, LOAD, 1'b0, 8'h55, 8'h00);
    check_all("reset_hold", 0, 0, 0, 0);

    // Load and hold.
    step(1'b1, 1'b1, LOAD, 1'b0, 8'h55, 8'h00);
    check_all("load", 8'h55, 0, 0, 1);
    step(1'b1, 1'b0, LOAD, 1'b0, 8'hAA, 8'h00);
    check_all("hold", 8'h55, 0, 0, 1);

    // Add with carry, sticky overflow, LOAD clears ovf.
    step(1'b1, 1'b1, ADD, 1'b1, 8'h00, 8'hFF);
    check_all("add_carry", 8'h54, 1, 1, 2);
    step(1'b1, 1'b1, ADD, 1'b1, 8'h00, 8'h01);
    check_all("add_sticky", 8'h55, 0, 1, 3);
    step(1'b1, 1'b1, LOAD, 1'b1, 8'h00, 8'h00);
    check_all("load_clr", 0, 0, 0, 4);

    // Subtract with borrow.
    step(1'b1, 1'b1, LOAD, 1'b0, 8'h10, 8'h00);
    step(1'b1, 1'b1, SUB, 1'b1, 8'h00, 8'h20);
    check_all("sub_borrow", 8'hF0, 1, 1, 6);
    step(1'b1, 1'b1, SUB, 1'b1, 8'h00, 8'hF0);
    check_all("sub_zero", 0, 0, 1, 7);

    // Rotate.
    step(1'b1, 1'b1, LOAD, 1'b0, 8'h81, 8'h00);
    step(1'b1, 1'b1, ROTL, 1'b0, 8'h00, 8'h00);
    check_all("rotl1", 8'h03, 1, 0, 9);
    step(1'b1, 1'b1, ROTL, 1'b0, 8'h00, 8'h00);
    check_all("rotl2", 8'h06, 0, 0, 10);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, ROTL, 1'b0, 8'h00, 8'h00);
    check_all("rotl8", 8'h06, 0, 0, 15);

    // Counter saturation.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, LOAD, 1'b0, 8'(i + 1), 8'h00);
    check_all("ops_sat", 20, 0, 0, 15);

    // Mid-operation reset during an ADD.
    step(1'b1, 1'b1, ADD, 1'b1, 8'h00, 8'hFF);
    check_all("pre_rst", 19, 1, 1, 15);
    step(1'b0, 1'b1, ADD, 1'b1, 8'h00, 8'hFF);
    check_all("mid_rst", 0, 0, 0, 0);

    // Randomized run against the reference model.
    m_q = 0; m_c = 0; m_ovf = 0; m_ops = 0;
    for (int i = 0; i < 300; i++) begin
      logic       r_rst, r_en, r_sel;
      logic [1:0] r_md;
      logic [7:0] r_a, r_b;
      r_rst = ($urandom_range(0, 39) != 0);
      r_en  = ($urandom_range(0, 3) != 0);
      r_md  = 2'($urandom_range(0, 3));
      r_sel = 1'($urandom_range(0, 1));
      r_a   = 8'($urandom);
      r_b   = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      step(r_rst, r_en, r_md, r_sel, r_a, r_b);
      model(r_rst, r_en, int'(r_md), r_sel ? int'(r_b) : int'(r_a));
      check_all("rand", m_q, m_c, m_ovf, m_ops);
    end

    // Three-channel build: select 3 is out of range and uses channel 0.
    step3(LOAD, 2'd3, {8'h33, 8'h22, 8'h11});
    check("sel3_q", 32'(bus3.q), 32'h11);
    step3(LOAD, 2'd2, {8'h33, 8'h22, 8'h11});
    check("sel2_q", 32'(bus3.q), 32'h33);
    step3(ADD, 2'd1, {8'h33, 8'h22, 8'h11});
    check("sel1_add", 32'(bus3.q), 32'h55);
    step3(ADD, 2'd3, {8'h33, 8'h22, 8'hC0});
    check("sel3_add_q", 32'(bus3.q), 32'h15);
    check("sel3_add_c", 32'(bus3.carry), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sel_acc_reg.md
Name: sel_acc_reg

Overview:
Parametrised N-channel selectable accumulator register, the successor to the 8-bit two-input mux-register used in the datapath exercises. Each enabled cycle it selects one of NUM_IN input words and either loads it or combines it with the stored value (add, subtract, rotate). It produces carry/borrow, a zero flag, a sticky overflow flag and a saturating operation counter. It sits between the operand buses and the result bus in the small datapath, clocked by the single system clock.

Parameters:
WIDTH, 8, data width in bits (>=2)
NUM_IN, 2, number of input channels (>=2)
CNT_W, 4, width of the saturating operation counter

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
enable  in  1  1 = perform operation this cycle; 0 = hold all state
sel  in  $clog2(NUM_IN)  input channel select
mode  in  2  00 LOAD, 01 ADD, 10 SUB, 11 ROTL
d  in  NUM_IN*WIDTH  packed inputs; channel k = d[k*WIDTH +: WIDTH]
q  out  WIDTH  registered result
carry  out  1  registered carry/borrow/rotated-out bit of the last operation
zero  out  1  combinational, 1 when q == 0
ovf  out  1  registered sticky arithmetic overflow flag
ops  out  CNT_W  registered count of enabled operations, saturating

Behaviour:
- One clock; reset is synchronous and active-low: sampled only on a clk rising edge with reset==0.
- Reset values: q=0, carry=0, ovf=0, ops=0, so zero=1.
- Reset has priority over enable. Reset asserted mid-sequence clears everything on that edge, regardless of enable, mode or sel.
- operand x = channel sel. If sel >= NUM_IN (non-power-of-2 NUM_IN), x = channel 0.
- enable==0: q, carry, ovf and ops all hold.
- enable==1, latency 1 cycle (result visible after the edge):
  - LOAD: q<=x; carry<=0; ovf<=0 (LOAD clears the sticky flag).
  - ADD: {carry,q} <= {1'b0,q} + {1'b0,x} (WIDTH+1-bit sum); ovf <= ovf | carry_out.
  - SUB: q <= q - x mod 2^WIDTH; carry <= 1 when x > q (unsigned borrow); ovf <= ovf | borrow.
  - ROTL: q <= {q[WIDTH-2:0], q[WIDTH-1]}; carry <= q[WIDTH-1]; ovf unchanged.
- ops increments by 1 on every enabled cycle, including LOAD. It holds at 2^CNT_W-1 (no wrap). Only reset clears it.
- Wrap-around: ADD/SUB results wrap modulo 2^WIDTH, and the carry/borrow is reported.
- No handshake; every enabled cycle is an accepted operation.
- The zero flag follows q with no extra cycle of delay.
- Inputs changing while enable==0 have no effect.

Test Plan:
(WIDTH=8, NUM_IN=2, CNT_W=4; d0=a, d1=b)
- Reset: reset=0 for 1 edge with enable=1, mode=LOAD, a=0x55 -> q=0x00, zero=1, carry=0, ovf=0, ops=0. Hold reset=0 for 3 more edges -> unchanged.
- Load/hold: reset=1, enable=1, LOAD sel=0, a=0x55 -> q=0x55, ops=1. Next enable=0, a=0xAA -> q stays 0x55, ops=1.
- Add with carry: q=0x55, ADD sel=1, b=0xFF -> q=0x54, carry=1, ovf=1. Then ADD sel=1, b=0x01 -> q=0x55, carry=0, ovf stays 1. Then LOAD sel=1, b=0x00 -> q=0, zero=1, ovf=0.
- Sub with borrow: LOAD a=0x10, SUB sel=1, b=0x20 -> q=0xF0, carry=1, ovf=1. Then SUB b=0xF0 -> q=0x00, carry=0, zero=1.
- Rotate: LOAD a=0x81, ROTL -> q=0x03, carry=1. ROTL again -> q=0x06, carry=0. Eight consecutive ROTLs return q to its starting value.
- Counter saturation + mid-op reset: 20 enabled cycles -> ops=15 and holds. Assert reset=0 during an ADD cycle -> q=0, ops=0, ovf=0 on that edge. NUM_IN=3 build with sel=3 -> channel 0 used.
